// File: rtl/stable_sig_a_driver.sv
// stable_sig_a_driver
//
// Drives sig_a from a valid/ready upstream. Every change on sig_a is held for
// at least MIN_HOLD rising edges before the next change is accepted, so a
// downstream $stable-style checker only ever sees legal transitions.
//
// Ports
//   clk           only clock, rising edge
//   rst           asynchronous active-low reset
//   in_valid      upstream offers in_data
//   in_data       offered value (WIDTH)
//   in_ready      block accepts this cycle: IDLE and not frozen
//   freeze        blocks acceptance and holds sig_a while high
//   sig_a         registered output (WIDTH)
//   sig_changed   one-cycle pulse after sig_a updated
//   same_drop     one-cycle pulse after an accepted value equal to sig_a
//   hold_busy     hold window running
//   change_count  saturating count of sig_a changes (CNT_W)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready to accept (unless frozen)
// HOLD  | sig_a just changed; hcnt counts down the remaining hold edges

module stable_sig_a_driver #(
   parameter int               WIDTH     = 1,
   parameter int               MIN_HOLD  = 4,
   parameter int               CNT_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             freeze,
   output logic [WIDTH-1:0] sig_a,
   output logic             sig_changed,
   output logic             same_drop,
   output logic             hold_busy,
   output logic [CNT_W-1:0] change_count
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // The changing edge itself and the final hcnt==0 edge both count toward
   // the window, so the counter starts two below MIN_HOLD.
   localparam logic [7:0] HOLD_INIT = (MIN_HOLD > 1) ? 8'(MIN_HOLD - 2) : 8'd0;

   state_t           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic [WIDTH-1:0] sig_a_q, sig_a_d;
   logic             sig_changed_q, sig_changed_d;
   logic             same_drop_q, same_drop_d;
   logic [CNT_W-1:0] change_count_q, change_count_d;
   logic             accept;

   assign in_ready     = (state_q == IDLE) && !freeze;
   assign accept       = in_valid && in_ready;
   assign sig_a        = sig_a_q;
   assign sig_changed  = sig_changed_q;
   assign same_drop    = same_drop_q;
   assign hold_busy    = (state_q == HOLD);
   assign change_count = change_count_q;

   always_comb begin
      state_d        = state_q;
      hcnt_d         = hcnt_q;
      sig_a_d        = sig_a_q;
      sig_changed_d  = 1'b0;
      same_drop_d    = 1'b0;
      change_count_d = change_count_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_data != sig_a_q) begin
                  sig_a_d       = in_data;
                  sig_changed_d = 1'b1;
                  if (!(&change_count_q)) begin
                     change_count_d = change_count_q + CNT_W'(1);
                  end
                  if (MIN_HOLD > 1) begin
                     hcnt_d  = HOLD_INIT;
                     state_d = HOLD;
                  end
               end else begin
                  same_drop_d = 1'b1;
               end
            end
         end
         HOLD: begin
            // freeze deliberately does not pause the countdown
            if (hcnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            hcnt_d  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         hcnt_q         <= 8'd0;
         sig_a_q        <= RESET_VAL;
         sig_changed_q  <= 1'b0;
         same_drop_q    <= 1'b0;
         change_count_q <= '0;
      end else begin
         state_q        <= state_d;
         hcnt_q         <= hcnt_d;
         sig_a_q        <= sig_a_d;
         sig_changed_q  <= sig_changed_d;
         same_drop_q    <= same_drop_d;
         change_count_q <= change_count_d;
      end
   end

endmodule
